instruction_fetch: RTL and testbench

//  Requester side of the instruction-memory interface: owns the PC, drives the byte address to the

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Requester side of the instruction-memory interface. Owns the PC, drives the
//   byte address to a clocked instruction memory (1-cycle read latency) and
//   pairs each returned word with the PC it was fetched from. Instructions are
//   handed to decode over valid/ready; taken branches/jumps redirect fetch.
//
//   Optional feature macro: IFETCH_BOUND_CHECK_EN
//     defined   : fetches at or beyond IMEM_WORDS*4 are flagged, fetch freezes
//                 and fetch_fault stays set until a redirect or reset.
//     undefined : no range check, fetch_fault tied low.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   imem_address      byte address to instruction memory (combinational)
//   imem_instruction  word returned for the address driven last cycle
//   instr_valid/ready decode handshake; instr/instr_pc carry the payload
//   redirect_valid/pc restart fetch at redirect_pc (bits [1:0] ignored)
//   fetch_fault       sticky out-of-range indication (bound-check build only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int                   WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
   parameter int                   IMEM_WORDS = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [WORD_SIZE-1:0] imem_address,
   input  logic [WORD_SIZE-1:0] imem_instruction,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [WORD_SIZE-1:0] instr,
   output logic [WORD_SIZE-1:0] instr_pc,
   input  logic                 redirect_valid,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 fetch_fault
);

   localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

   logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;     // next address to issue
   logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;   // address issued last cycle
   logic                 resp_valid_q, resp_valid_d;
   logic [WORD_SIZE-1:0] redir_pc;
   logic                 advance;
   logic                 frozen;

`ifdef IFETCH_BOUND_CHECK_EN
   localparam logic [WORD_SIZE-1:0] IMEM_BYTES = WORD_SIZE'(IMEM_WORDS * 4);
   logic fault_q, fault_d;
   logic fault_cond;
   assign fault_cond = resp_valid_q & (resp_pc_q >= IMEM_BYTES);
   // fault_cond persists while frozen (resp_pc held), fault_q covers it anyway
   assign frozen     = fault_cond | fault_q;
`else
   assign frozen     = 1'b0;
`endif

   assign redir_pc = {redirect_pc[WORD_SIZE-1:2], 2'b00};
   // Pipeline moves when nothing is held or decode takes what is held
   assign advance  = ~resp_valid_q | instr_ready;
   assign instr    = imem_instruction;

   always_comb begin
      req_pc_d     = req_pc_q;
      resp_pc_d    = resp_pc_q;
      resp_valid_d = resp_valid_q;
      imem_address = resp_pc_q;
      instr_valid  = 1'b0;
      instr_pc     = resp_pc_q;
      fetch_fault  = 1'b0;
`ifdef IFETCH_BOUND_CHECK_EN
      fault_d      = fault_q;
`endif
      if (reset) begin
         // memory output is garbage during reset; present nothing
         imem_address = RESET_PC;
         instr_pc     = '0;
      end else begin
`ifdef IFETCH_BOUND_CHECK_EN
         instr_valid = resp_valid_q & ~redirect_valid & ~fault_cond;
         fetch_fault = fault_q;
`else
         instr_valid = resp_valid_q & ~redirect_valid;
`endif
         if (redirect_valid) begin
            // held instruction is squashed; one bubble while the target is read
            imem_address = redir_pc;
            resp_pc_d    = redir_pc;
            resp_valid_d = 1'b1;
            req_pc_d     = redir_pc + PC_STEP;
`ifdef IFETCH_BOUND_CHECK_EN
            fault_d      = 1'b0;
`endif
         end else if (frozen) begin
            imem_address = resp_pc_q;
`ifdef IFETCH_BOUND_CHECK_EN
            fault_d      = 1'b1;
`endif
         end else if (advance) begin
            imem_address = req_pc_q;
            resp_pc_d    = req_pc_q;
            resp_valid_d = 1'b1;
            req_pc_d     = req_pc_q + PC_STEP;
         end else begin
            // stall: re-read resp_pc so the memory output keeps matching it
            imem_address = resp_pc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_pc_q     <= RESET_PC;
         resp_pc_q    <= '0;
         resp_valid_q <= 1'b0;
`ifdef IFETCH_BOUND_CHECK_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         req_pc_q     <= req_pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_valid_q <= resp_valid_d;
`ifdef IFETCH_BOUND_CHECK_EN
         fault_q      <= fault_d;
`endif
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   localparam logic [31:0] RP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, instr_ready, redirect_valid;
   logic [31:0] redirect_pc, imem_address, imem_instruction, instr, instr_pc;
   logic        instr_valid, fetch_fault;

   logic [31:0] mem [0:1023];

   int tests = 0;
   int fails = 0;

   // stream model: m_vis = an instruction is presented this cycle, m_pc = its pc
   logic        m_vis = 1'b0;
   logic [31:0] m_pc = RP;
   logic        n_vis, exp_valid;
   logic [31:0] n_pc, exp_addr;

   instruction_fetch #(.WORD_SIZE(32), .RESET_PC(RP), .IMEM_WORDS(1024)) dut (
      .clk(clk), .reset(reset), .imem_address(imem_address),
      .imem_instruction(imem_instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // clocked memory, 1-cycle latency, truncates the address
   always @(posedge clk) imem_instruction <= mem[imem_address[11:2]];

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   // drive inputs after the falling edge and derive what the stream should show
   task automatic apply(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      reset = r; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      exp_valid = m_vis & ~rv & ~r;
      if (r)                n_pc = RP;
      else if (rv)          n_pc = {rpc[31:2], 2'b00};
      else if (m_vis & rdy) n_pc = m_pc + 32'd4;
      else                  n_pc = m_pc;
      n_vis    = ~r;
      exp_addr = n_pc;   // memory must be reading what is shown next cycle
   endtask

   task automatic tick();
      m_pc  = n_pc;
      m_vis = n_vis;
      @(negedge clk);
   endtask

   task automatic test_reset(input logic rdy);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, rdy, 1'b0, 32'h0);
         tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
         tests++; if (imem_address !== RP) begin fails++; $display("FAIL rst_addr: got %h want %h", imem_address, RP); end
         tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
         tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 1'b0, 32'h0);
         tests++; if (instr_valid !== (i > 0)) begin fails++; $display("FAIL start_valid%0d: got %b want %b", i, instr_valid, i > 0); end
         tests++; if (imem_address !== RP + 32'(4 * i)) begin fails++; $display("FAIL start_addr%0d: got %h want %h", i, imem_address, RP + 32'(4 * i)); end
         if (i > 0) begin
            tests++; if (instr_pc !== RP + 32'(4 * (i - 1))) begin fails++; $display("FAIL start_pc%0d: got %h want %h", i, instr_pc, RP + 32'(4 * (i - 1))); end
            tests++; if (instr !== mem[i - 1]) begin fails++; $display("FAIL start_instr%0d: got %h want %h", i, instr, mem[i - 1]); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, 32'h0);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin fails++; $display("FAIL stall_pc: got %b/%h want 1/8", instr_valid, instr_pc); end
         tests++; if (instr !== mem[2]) begin fails++; $display("FAIL stall_instr: got %h want %h", instr, mem[2]); end
         tests++; if (imem_address !== 32'h8) begin fails++; $display("FAIL stall_addr: got %h want 8", imem_address); end
         tick();
      end
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (instr_pc !== 32'h8 || imem_address !== 32'hC) begin fails++; $display("FAIL stall_release: got %h/%h want 8/c", instr_pc, imem_address); end
      tick();
   endtask

   task automatic test_redirect();
      apply(1'b0, 1'b1, 1'b1, 32'h40);
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_squash: got %b want 0", instr_valid); end
      tests++; if (instr_pc !== 32'hC) begin fails++; $display("FAIL redir_oldpc: got %h want c", instr_pc); end
      tests++; if (imem_address !== 32'h40) begin fails++; $display("FAIL redir_addr: got %h want 40", imem_address); end
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b1, 1'b0, 32'h0);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 + 32'(4 * i)) begin fails++; $display("FAIL redir_pc%0d: got %b/%h want 1/%h", i, instr_valid, instr_pc, 32'h40 + 32'(4 * i)); end
         tests++; if (instr !== mem[16 + i]) begin fails++; $display("FAIL redir_instr%0d: got %h want %h", i, instr, mem[16 + i]); end
         tick();
      end
   endtask

   task automatic test_redirect_stall();
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      tests++; if (instr_pc !== 32'h48 || imem_address !== 32'h48) begin fails++; $display("FAIL rs_stall: got %h/%h want 48/48", instr_pc, imem_address); end
      tick();
      apply(1'b0, 1'b1, 1'b1, 32'h43);
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rs_squash: got %b want 0", instr_valid); end
      tests++; if (imem_address !== 32'h40) begin fails++; $display("FAIL rs_align: got %h want 40", imem_address); end
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b1, 1'b0, 32'h0);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 + 32'(4 * i)) begin fails++; $display("FAIL rs_pc%0d: got %b/%h want 1/%h", i, instr_valid, instr_pc, 32'h40 + 32'(4 * i)); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      test_reset(1'b0);
   endtask

   task automatic test_random();
      logic r, rdy, rv;
      logic [31:0] rpc;
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 9) == 0) || (m_pc >= 32'hE00);
         rpc = $urandom_range(0, 32'hDFF);
         apply(r, rdy, rv, rpc);
         tests++; if (instr_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", i, instr_valid, exp_valid); end
         tests++; if (imem_address !== exp_addr) begin fails++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_address, exp_addr); end
         tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL rnd_fault@%0d: got %b want 0", i, fetch_fault); end
         if (exp_valid) begin
            tests++; if (instr_pc !== m_pc) begin fails++; $display("FAIL rnd_pc@%0d: got %h want %h", i, instr_pc, m_pc); end
            tests++; if (instr !== mem[m_pc[11:2]]) begin fails++; $display("FAIL rnd_instr@%0d: got %h want %h", i, instr, mem[m_pc[11:2]]); end
         end
         tick();
      end
   endtask

`ifdef IFETCH_BOUND_CHECK_EN
   task automatic test_bound();
      apply(1'b0, 1'b1, 1'b1, 32'hFFC); tick();
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFC) begin fails++; $display("FAIL bnd_last: got %b/%h want 1/ffc", instr_valid, instr_pc); end
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 1'b0, 32'h0);
         tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL bnd_valid%0d: got %b want 0", i, instr_valid); end
         tests++; if (imem_address !== 32'h1000) begin fails++; $display("FAIL bnd_addr%0d: got %h want 1000", i, imem_address); end
         tests++; if (fetch_fault !== (i > 0)) begin fails++; $display("FAIL bnd_fault%0d: got %b want %b", i, fetch_fault, i > 0); end
         tick();
      end
      apply(1'b0, 1'b1, 1'b1, 32'h0);
      tests++; if (fetch_fault !== 1'b1 || imem_address !== 32'h0) begin fails++; $display("FAIL bnd_redir: got %b/%h want 1/0", fetch_fault, imem_address); end
      tick();
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (fetch_fault !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL bnd_clear: got %b/%b/%h want 0/1/0", fetch_fault, instr_valid, instr_pc); end
      tick();
   endtask
`else
   task automatic test_wrap();
      apply(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      tests++; if (imem_address !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr: got %h want fffffffc", imem_address); end
      tick();
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", instr_valid, instr_pc); end
      tests++; if (imem_address !== 32'h0) begin fails++; $display("FAIL wrap_next: got %h want 0", imem_address); end
      tick();
      apply(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem[0]) begin fails++; $display("FAIL wrap_zero: got %b/%h/%h want 1/0/%h", instr_valid, instr_pc, instr, mem[0]); end
      tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL wrap_fault: got %b want 0", fetch_fault); end
      tick();
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      @(negedge clk);
      test_reset(1'b1);
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_reset_mid();
      test_random();
`ifdef IFETCH_BOUND_CHECK_EN
      test_bound();
`else
      test_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
